// File: rtl/tom_bus_arbiter.sv
// tom_bus_arbiter: registered arbiter for the shared 64-bit main-memory bus.
//
// The CPU is the parked default owner. The DMA engine, the blitter (high and normal levels) and
// the GPU request the bus. Ownership changes always pass through a handoff gap of TURN dead
// cycles. Bus lock and outstanding memory cycles are honoured. GPU and normal-level blitter
// grants lose the bus after TENURE cycles if another non-CPU request is waiting.
//
// Ports:
//   sys_clk     in   system clock, rising edge
//   reset       in   synchronous reset, active-high
//   dma_breq    in   DMA request (highest priority)
//   blit_breq   in   [1] blitter high-level request, [0] normal-level request
//   gpu_breq    in   GPU request
//   mem_busy    in   current owner has a memory cycle outstanding
//   lock        in   current owner forbids revocation
//   dma_back    out  DMA grant
//   blit_back   out  blitter grant
//   gpu_back    out  GPU grant
//   cpu_bg      out  CPU grant (park)
//   preempt     out  revocation of the current owner is pending
//   owner       out  0 none, 1 CPU, 2 GPU, 3 blitter, 4 DMA
//   turnaround  out  handoff gap in progress
module tom_bus_arbiter #(
    parameter int unsigned TENURE = 64,
    parameter int unsigned TURN   = 1
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       dma_breq,
    input  logic [1:0] blit_breq,
    input  logic       gpu_breq,
    input  logic       mem_busy,
    input  logic       lock,
    output logic       dma_back,
    output logic       blit_back,
    output logic       gpu_back,
    output logic       cpu_bg,
    output logic       preempt,
    output logic [2:0] owner,
    output logic       turnaround
);

    localparam logic [1:0] StPark    = 2'd0;
    localparam logic [1:0] StGrant   = 2'd1;
    localparam logic [1:0] StHandoff = 2'd2;

    localparam logic [2:0] OwnNone = 3'd0;
    localparam logic [2:0] OwnCpu  = 3'd1;
    localparam logic [2:0] OwnGpu  = 3'd2;
    localparam logic [2:0] OwnBlit = 3'd3;
    localparam logic [2:0] OwnDma  = 3'd4;

    localparam logic [7:0] TenureLim = 8'(TENURE);
    localparam logic [2:0] TurnLast  = 3'(TURN - 1);

    logic [1:0] st_q, st_d;
    logic [2:0] own_q, own_d;
    logic [7:0] ten_q, ten_d;
    logic [2:0] turn_q, turn_d;
    logic       preempt_d;

    logic       dma_back_q, blit_back_q, gpu_back_q, cpu_bg_q, preempt_q, turnaround_q;
    logic [2:0] owner_q, owner_d;

    logic       any_req;
    logic [2:0] pick;
    logic       own_req, higher, tenured, others, expired, revoke, release_ok;

    assign any_req = dma_breq | (|blit_breq) | gpu_breq;

    // Winner at the end of the handoff gap; OwnCpu here means nobody is asking.
    always_comb begin
        if (dma_breq) begin
            pick = OwnDma;
        end else if (blit_breq[1]) begin
            pick = OwnBlit;
        end else if (gpu_breq) begin
            pick = OwnGpu;
        end else if (blit_breq[0]) begin
            pick = OwnBlit;
        end else begin
            pick = OwnCpu;
        end
    end

    // Release analysis for the current owner. The blitter's level follows blit_breq every
    // cycle, so a normal-level owner that raises [1] gains high-level protection.
    always_comb begin
        own_req = 1'b0;
        higher  = 1'b0;
        tenured = 1'b0;
        others  = 1'b0;
        case (own_q)
            OwnDma: begin
                own_req = dma_breq;
            end
            OwnBlit: begin
                own_req = |blit_breq;
                if (blit_breq[1]) begin
                    higher = dma_breq;
                end else begin
                    higher  = dma_breq | gpu_breq;
                    tenured = 1'b1;
                    others  = dma_breq | gpu_breq;
                end
            end
            OwnGpu: begin
                own_req = gpu_breq;
                higher  = dma_breq | blit_breq[1];
                tenured = 1'b1;
                others  = dma_breq | (|blit_breq);
            end
            default: ;
        endcase
        expired    = tenured && (ten_q >= TenureLim) && others;
        revoke     = higher | expired;
        // mem_busy holds everything; lock only protects against revocation.
        release_ok = !mem_busy && (!own_req || (revoke && !lock));
    end

    always_comb begin
        st_d      = st_q;
        own_d     = own_q;
        ten_d     = ten_q;
        turn_d    = turn_q;
        preempt_d = 1'b0;
        unique case (st_q)
            StPark: begin
                if (any_req && !mem_busy && !lock) begin
                    st_d   = StHandoff;
                    turn_d = 3'd0;
                end
            end
            StGrant: begin
                if (release_ok) begin
                    st_d   = StHandoff;
                    turn_d = 3'd0;
                end else begin
                    preempt_d = revoke;
                    if (ten_q != 8'hff) begin
                        ten_d = ten_q + 8'd1;
                    end
                end
            end
            StHandoff: begin
                // Requests are only looked at in the final gap cycle.
                if (turn_q == TurnLast) begin
                    if (any_req) begin
                        st_d  = StGrant;
                        own_d = pick;
                        ten_d = 8'd0;
                    end else begin
                        st_d = StPark;
                    end
                end else begin
                    turn_d = turn_q + 3'd1;
                end
            end
            default: begin
                st_d = StPark;
            end
        endcase
    end

    always_comb begin
        if (st_d == StHandoff) begin
            owner_d = OwnNone;
        end else if (st_d == StPark) begin
            owner_d = OwnCpu;
        end else begin
            owner_d = own_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            st_q         <= StPark;
            own_q        <= OwnCpu;
            ten_q        <= 8'd0;
            turn_q       <= 3'd0;
            dma_back_q   <= 1'b0;
            blit_back_q  <= 1'b0;
            gpu_back_q   <= 1'b0;
            cpu_bg_q     <= 1'b1;
            preempt_q    <= 1'b0;
            owner_q      <= OwnCpu;
            turnaround_q <= 1'b0;
        end else begin
            st_q         <= st_d;
            own_q        <= own_d;
            ten_q        <= ten_d;
            turn_q       <= turn_d;
            dma_back_q   <= (st_d == StGrant) && (own_d == OwnDma);
            blit_back_q  <= (st_d == StGrant) && (own_d == OwnBlit);
            gpu_back_q   <= (st_d == StGrant) && (own_d == OwnGpu);
            cpu_bg_q     <= (st_d == StPark);
            preempt_q    <= preempt_d;
            owner_q      <= owner_d;
            turnaround_q <= (st_d == StHandoff);
        end
    end

    assign dma_back   = dma_back_q;
    assign blit_back  = blit_back_q;
    assign gpu_back   = gpu_back_q;
    assign cpu_bg     = cpu_bg_q;
    assign preempt    = preempt_q;
    assign owner      = owner_q;
    assign turnaround = turnaround_q;

endmodule

// File: tb/tb_tom_bus_arbiter.sv
// tb_tom_bus_arbiter: bench for tom_bus_arbiter. Two instances share the request inputs:
// u0 (TENURE=4, TURN=1) and u1 (TENURE=10, TURN=3).
module tb_tom_bus_arbiter;

    localparam logic [2:0] DevGpu  = 3'd2;
    localparam logic [2:0] DevBlit = 3'd3;
    localparam logic [2:0] DevDma  = 3'd4;
    localparam int PhPark  = 0;
    localparam int PhGrant = 1;
    localparam int PhGap   = 2;

    localparam logic [8:0] VPark = 9'b000100010;
    localparam logic [8:0] VGap  = 9'b000000001;
    localparam logic [8:0] VGpu  = 9'b001000100;
    localparam logic [8:0] VGpuP = 9'b001010100;
    localparam logic [8:0] VBlit = 9'b010000110;
    localparam logic [8:0] VDma  = 9'b100001000;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       dma_breq  = 1'b0;
    logic [1:0] blit_breq = 2'b00;
    logic       gpu_breq  = 1'b0;
    logic       mem_busy  = 1'b0;
    logic       lock      = 1'b0;

    logic       dma_b0, blit_b0, gpu_b0, cpu_b0, pre0, ta0;
    logic       dma_b1, blit_b1, gpu_b1, cpu_b1, pre1, ta1;
    logic [2:0] own0, own1;
    logic [8:0] act0, act1;

    assign act0 = {dma_b0, blit_b0, gpu_b0, cpu_b0, pre0, own0, ta0};
    assign act1 = {dma_b1, blit_b1, gpu_b1, cpu_b1, pre1, own1, ta1};

    int total = 0;
    int bad   = 0;

    int         ten_lim [2] = '{4, 10};
    int         turn_len[2] = '{1, 3};
    int         m_ph  [2];
    logic [2:0] m_who [2];
    int         m_held[2];
    int         m_left[2];
    logic       m_pre [2];

    always #5 clk = ~clk;

    tom_bus_arbiter #(.TENURE(4), .TURN(1)) u0 (
        .sys_clk(clk), .reset(reset), .dma_breq(dma_breq), .blit_breq(blit_breq),
        .gpu_breq(gpu_breq), .mem_busy(mem_busy), .lock(lock), .dma_back(dma_b0),
        .blit_back(blit_b0), .gpu_back(gpu_b0), .cpu_bg(cpu_b0), .preempt(pre0),
        .owner(own0), .turnaround(ta0)
    );

    tom_bus_arbiter #(.TENURE(10), .TURN(3)) u1 (
        .sys_clk(clk), .reset(reset), .dma_breq(dma_breq), .blit_breq(blit_breq),
        .gpu_breq(gpu_breq), .mem_busy(mem_busy), .lock(lock), .dma_back(dma_b1),
        .blit_back(blit_b1), .gpu_back(gpu_b1), .cpu_bg(cpu_b1), .preempt(pre1),
        .owner(own1), .turnaround(ta1)
    );

    // Priority rank of a device's current request: DMA 4, blitter high 3, GPU 2,
    // blitter normal 1, nothing 0.
    function automatic int dev_rank(input logic [2:0] dev);
        case (dev)
            DevDma:  return dma_breq ? 4 : 0;
            DevBlit: return blit_breq[1] ? 3 : (blit_breq[0] ? 1 : 0);
            DevGpu:  return gpu_breq ? 2 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int best_rank(input logic [2:0] excl);
        int b;
        b = 0;
        for (int d = 2; d <= 4; d++) begin
            if (3'(d) != excl && dev_rank(3'(d)) > b) b = dev_rank(3'(d));
        end
        return b;
    endfunction

    function automatic logic [2:0] rank_dev(input int r);
        if (r == 4) return DevDma;
        if (r == 3 || r == 1) return DevBlit;
        return DevGpu;
    endfunction

    // One clock edge of the arbitration rules, applied to inputs as sampled at that edge.
    task automatic model_step();
        int   own_rank, bo;
        logic own_req, revoke, rel;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_ph[i]   = PhPark;
                m_pre[i]  = 1'b0;
                m_held[i] = 0;
            end else if (m_ph[i] == PhPark) begin
                m_pre[i] = 1'b0;
                if (best_rank(3'd0) != 0 && !mem_busy && !lock) begin
                    m_ph[i]   = PhGap;
                    m_left[i] = turn_len[i];
                end
            end else if (m_ph[i] == PhGap) begin
                m_pre[i] = 1'b0;
                if (m_left[i] == 1) begin
                    bo = best_rank(3'd0);
                    if (bo == 0) begin
                        m_ph[i] = PhPark;
                    end else begin
                        m_ph[i]   = PhGrant;
                        m_who[i]  = rank_dev(bo);
                        m_held[i] = 0;
                    end
                end else begin
                    m_left[i] = m_left[i] - 1;
                end
            end else begin
                if (m_who[i] == DevBlit) own_rank = blit_breq[1] ? 3 : 1;
                else if (m_who[i] == DevGpu) own_rank = 2;
                else own_rank = 4;
                own_req = dev_rank(m_who[i]) != 0;
                bo      = best_rank(m_who[i]);
                revoke  = (bo > own_rank) ||
                          ((own_rank <= 2) && (m_held[i] >= ten_lim[i]) && (bo != 0));
                rel     = !mem_busy && (!own_req || (revoke && !lock));
                if (rel) begin
                    m_ph[i]   = PhGap;
                    m_left[i] = turn_len[i];
                    m_pre[i]  = 1'b0;
                end else begin
                    m_pre[i]  = revoke;
                    m_held[i] = (m_held[i] < 255) ? m_held[i] + 1 : 255;
                end
            end
        end
    endtask

    function automatic logic [8:0] exp_vec(input int i);
        if (m_ph[i] == PhPark) return VPark;
        if (m_ph[i] == PhGap) return VGap;
        return {m_who[i] == DevDma, m_who[i] == DevBlit, m_who[i] == DevGpu, 1'b0, m_pre[i],
                m_who[i], 1'b0};
    endfunction

    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Advance n cycles; every cycle, step the model and compare both instances at negedge.
    task automatic cyc(input int n);
        logic [8:0] a;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                a = (i == 0) ? act0 : act1;
                chk($sformatf("model_u%0d", i), a, exp_vec(i));
                chk_int($sformatf("exclusive_u%0d", i),
                        int'(($countones(a[8:5]) <= 1) && !(a[0] && (|a[8:5]))), 1);
            end
        end
    endtask

    initial begin
        int held;
        cyc(2);
        reset = 1'b0;
        cyc(10);
        chk("idle_park", act0, VPark);

        // Park -> GPU with TURN=1, then voluntary release.
        gpu_breq = 1'b1;
        cyc(1); chk("req_gap", act0, VGap);
        cyc(1); chk("gpu_grant", act0, VGpu);
        cyc(2);
        gpu_breq = 1'b0;
        cyc(1); chk("vol_gap", act0, VGap);
        cyc(1); chk("vol_park", act0, VPark);
        cyc(3);

        // DMA arrives while the GPU has a memory cycle outstanding.
        gpu_breq = 1'b1;
        cyc(2);
        dma_breq = 1'b1; mem_busy = 1'b1;
        cyc(1); chk("busy_preempt", act0, VGpuP);
        cyc(2); chk("busy_hold", act0, VGpuP);
        mem_busy = 1'b0;
        cyc(1); chk("busy_gap", act0, VGap);
        cyc(1); chk("busy_dma", act0, VDma);
        dma_breq = 1'b0; gpu_breq = 1'b0;
        cyc(5);

        // Lock blocks revocation but not voluntary release.
        gpu_breq = 1'b1;
        cyc(2);
        lock = 1'b1; dma_breq = 1'b1;
        cyc(1); chk("lock_preempt", act0, VGpuP);
        cyc(2);
        lock = 1'b0;
        cyc(1); chk("lock_gap", act0, VGap);
        cyc(1); chk("lock_dma", act0, VDma);
        dma_breq = 1'b0;
        cyc(2); chk("lock_gpu_again", act0, VGpu);
        lock = 1'b1; gpu_breq = 1'b0;
        cyc(1); chk("lock_vol_gap", act0, VGap);
        cyc(1); chk("lock_vol_park", act0, VPark);

        // Lock also holds the CPU park.
        gpu_breq = 1'b1;
        cyc(2); chk("park_locked", act0, VPark);
        lock = 1'b0;
        cyc(1); chk("park_unlock_gap", act0, VGap);
        gpu_breq = 1'b0;
        cyc(4);

        // Tenure: GPU loses the bus once 4 grant cycles are used up with the blitter waiting.
        gpu_breq = 1'b1;
        cyc(2); chk("ten_gpu_grant", act0, VGpu);
        blit_breq = 2'b01;
        cyc(4); chk("ten_gpu_held", act0, VGpu);
        cyc(1); chk("ten_expire_gap", act0, VGap);
        gpu_breq = 1'b0;
        cyc(1); chk("ten_blit_grant", act0, VBlit);
        gpu_breq = 1'b1;
        cyc(1); chk("blit_lo_revoke_gap", act0, VGap);
        blit_breq = 2'b00;
        cyc(1); chk("gpu_regrant", act0, VGpu);
        gpu_breq = 1'b0;
        cyc(5);

        // High-level blitter never expires.
        blit_breq = 2'b10;
        cyc(2); chk("blit_hi_grant", act0, VBlit);
        gpu_breq = 1'b1;
        held = 0;
        for (int k = 0; k < 300; k++) begin
            cyc(1);
            if (act0 == VBlit) held++;
        end
        chk_int("blit_hi_held_cycles", held, 300);
        blit_breq = 2'b00;
        cyc(1); chk("blit_hi_gap", act0, VGap);
        cyc(1); chk("blit_hi_then_gpu", act0, VGpu);
        gpu_breq = 1'b0;
        cyc(5);

        // Everyone pending at once: DMA wins; reset mid-grant parks without a gap.
        dma_breq = 1'b1; blit_breq = 2'b11; gpu_breq = 1'b1;
        cyc(1); chk("all_gap", act0, VGap);
        cyc(1); chk("all_dma", act0, VDma);
        reset = 1'b1; dma_breq = 1'b0; blit_breq = 2'b00; gpu_breq = 1'b0;
        cyc(1); chk("reset_park", act0, VPark);
        reset = 1'b0;
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
